// File: rtl/song_sequencer.sv
// -----------------------------------------------------------------------------
// song_sequencer
//   Autoplay controller for the piano. Walks an internal melody ROM and drives
//   a note code into the switch/frequency mux. Each note is held for its beat
//   count, and a silent gap is inserted at the end of each note so that
//   repeated notes sound separately.
//
//   Optional feature: define SONG_LOOP_EN to restart from index 0 at the end of
//   the song (done still pulses once per pass) instead of returning to IDLE.
//
// Ports
//   CLK      in   system clock
//   RESET    in   asynchronous active-low reset
//   start    in   one-cycle pulse, begins playback from index 0 (IDLE only)
//   stop     in   one-cycle pulse, aborts playback from any state
//   pause    in   one-cycle pulse, toggles PLAY/GAP <-> PAUSED
//   note     out  note code (C4=0 .. C5=7, none=15)
//   playing  out  high in FETCH, PLAY, GAP and PAUSED
//   paused   out  high in PAUSED
//   index    out  ROM address of the current note
//   done     out  one-cycle pulse at end of song
// -----------------------------------------------------------------------------
module song_sequencer #(
    parameter int unsigned BEAT_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES  = 2_500_000,
    parameter int unsigned SONG_LEN    = 16
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        pause,
    output logic [3:0]                  note,
    output logic                        playing,
    output logic                        paused,
    output logic [$clog2(SONG_LEN)-1:0] index,
    output logic                        done
);

    localparam int unsigned IDX_W  = $clog2(SONG_LEN);
    // One extra bit so the pointer can reach SONG_LEN, which reads as the end
    localparam int unsigned PTR_W  = IDX_W + 1;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned NOTE_W = 4;
    localparam logic [NOTE_W-1:0] NOTE_NONE = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PLAY,
        S_GAP,
        S_PAUSED
    } state_t;

    // Melody ROM: {dur[7:4], code[3:0]}; dur=0 marks the end of the song
    function automatic logic [7:0] rom_word(input logic [PTR_W-1:0] addr);
        logic [7:0] w;
        case (int'(addr))
            0:       w = 8'h12;  // E  1
            1:       w = 8'h12;  // E  1
            2:       w = 8'h13;  // F  1
            3:       w = 8'h14;  // G  1
            4:       w = 8'h14;  // G  1
            5:       w = 8'h13;  // F  1
            6:       w = 8'h12;  // E  1
            7:       w = 8'h11;  // D  1
            8:       w = 8'h10;  // C  1
            9:       w = 8'h10;  // C  1
            10:      w = 8'h11;  // D  1
            11:      w = 8'h12;  // E  1
            12:      w = 8'h22;  // E  2
            13:      w = 8'h11;  // D  1
            14:      w = 8'h21;  // D  2
            default: w = 8'h00;  // end marker
        endcase
        return w;
    endfunction

    state_t                  state, state_n;
    state_t                  resume_q, resume_n;
    logic [CNT_W-1:0]        cnt_q, cnt_n;
    logic [PTR_W-1:0]        ptr_q, ptr_n;
    logic [NOTE_W-1:0]       code_q, code_n;

    logic [7:0]              rom_q;
    logic [3:0]              rom_dur;
    logic [NOTE_W-1:0]       rom_code;
    logic                    end_hit;
    logic                    stop_act;
    logic [CNT_W-1:0]        play_load;

    logic [NOTE_W-1:0]       note_d;
    logic                    playing_d;
    logic                    paused_d;
    logic [IDX_W-1:0]        index_d;
    logic                    done_d;

    // ROM lookup and derived values for the FETCH decision
    always_comb begin
        rom_q     = rom_word(ptr_q);
        rom_dur   = rom_q[7:4];
        rom_code  = rom_q[3:0];
        end_hit   = (ptr_q >= PTR_W'(SONG_LEN)) || (rom_dur == 4'd0);
        // Gap is carved out of the note's beat time; -1 because cnt=0 is the last cycle
        play_load = CNT_W'(rom_dur) * CNT_W'(BEAT_CYCLES) - CNT_W'(GAP_CYCLES) - CNT_W'(1);
        stop_act  = stop && (state != S_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= S_IDLE;
            resume_q <= S_PLAY;
            cnt_q    <= '0;
            ptr_q    <= '0;
            code_q   <= NOTE_NONE;
        end else begin
            state    <= state_n;
            resume_q <= resume_n;
            cnt_q    <= cnt_n;
            ptr_q    <= ptr_n;
            code_q   <= code_n;
        end
    end

    // Next-state, counter and pointer logic
    always_comb begin
        state_n  = state;
        resume_n = resume_q;
        cnt_n    = cnt_q;
        ptr_n    = ptr_q;
        code_n   = code_q;

        case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    state_n = S_FETCH;
                    ptr_n   = '0;
                end
            end
            S_FETCH: begin
                if (end_hit) begin
                    ptr_n = '0;
`ifdef SONG_LOOP_EN
                    state_n = S_FETCH;
`else
                    state_n = S_IDLE;
`endif
                end else begin
                    code_n  = rom_code;
                    cnt_n   = play_load;
                    state_n = S_PLAY;
                end
            end
            S_PLAY: begin
                // Pause freezes cnt; the current cycle is not consumed
                if (pause) begin
                    resume_n = S_PLAY;
                    state_n  = S_PAUSED;
                end else if (cnt_q == '0) begin
                    cnt_n   = CNT_W'(GAP_CYCLES) - CNT_W'(1);
                    state_n = S_GAP;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            S_GAP: begin
                if (pause) begin
                    resume_n = S_GAP;
                    state_n  = S_PAUSED;
                end else if (cnt_q == '0) begin
                    ptr_n   = ptr_q + PTR_W'(1);
                    state_n = S_FETCH;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            S_PAUSED: begin
                if (pause) begin
                    state_n = resume_q;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // stop overrides everything outside IDLE
        if (stop_act) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            ptr_n   = '0;
        end
    end

    // Output decode; stop and pause take effect in the same register update
    always_comb begin
        note_d    = NOTE_NONE;
        playing_d = 1'b0;
        paused_d  = 1'b0;
        index_d   = ptr_q[IDX_W-1:0];
        done_d    = 1'b0;

        if (stop_act) begin
            index_d = '0;
        end else begin
            case (state)
                S_FETCH: begin
                    playing_d = 1'b1;
                    done_d    = end_hit;
                end
                S_PLAY: begin
                    playing_d = 1'b1;
                    paused_d  = pause;
                    if (!pause) begin
                        note_d = code_q;
                    end
                end
                S_GAP: begin
                    playing_d = 1'b1;
                    paused_d  = pause;
                end
                S_PAUSED: begin
                    playing_d = 1'b1;
                    paused_d  = !pause;
                end
                default: begin
                    note_d = NOTE_NONE;
                end
            endcase
        end
    end

    // Registered outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            note    <= NOTE_NONE;
            playing <= 1'b0;
            paused  <= 1'b0;
            index   <= '0;
            done    <= 1'b0;
        end else begin
            note    <= note_d;
            playing <= playing_d;
            paused  <= paused_d;
            index   <= index_d;
            done    <= done_d;
        end
    end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Autoplay controller for the piano: steps through an internal melody ROM and drives a note code for each note.
- The note code feeds the existing switch/frequency mux, and each note is held for a programmable number of beats.
- Inserts a silent gap between notes so that repeated notes are audible as separate notes.
- Supports start, stop and pause/resume, and reports the current position and end of song.

Parameters:
- BEAT_CYCLES, 25_000_000: CLK cycles per beat (250 ms at 100 MHz). Must be greater than GAP_CYCLES.
- GAP_CYCLES, 2_500_000: silent CLK cycles at the end of every note. Counted inside the note's beat time.
- SONG_LEN, 16: number of ROM entries. The index width is clog2(SONG_LEN).

Ports:
- CLK, input, 1: system clock.
- RESET, input, 1: asynchronous, active-low reset. The block is in reset while RESET=0.
- start, input, 1: one-cycle pulse. Begins playback from index 0. Honoured only in IDLE.
- stop, input, 1: one-cycle pulse. Aborts playback from any state.
- pause, input, 1: one-cycle pulse. Toggles between PLAY/GAP and PAUSED.
- note, output, 4: note code. C4=0, D=1, E=2, F=3, G=4, A=5, B=6, C5=7; none=15.
- playing, output, 1: high in FETCH, PLAY, GAP and PAUSED.
- paused, output, 1: high in PAUSED only.
- index, output, clog2(SONG_LEN): ROM address of the current note.
- done, output, 1: one-cycle pulse at end of song.

Behaviour:

ROM and note rules:
- Each ROM word is 8 bits: {dur[7:4], code[3:0]}. dur is a beat count from 1 to 15.
- dur=0 is an end marker.
- code=15 is a rest: timing is identical to a note, but the note output stays at none.
- ROM contents (code/dur), indices 0-14: E1 E1 F1 G1 G1 F1 E1 D1 C1 C1 D1 E1 E2 D1 D2. Index 15 is the end marker.
- Reaching index SONG_LEN is treated as the end marker.

Reset (RESET=0, takes effect asynchronously): state=IDLE, note=15, playing=0, paused=0, index=0, done=0, counters=0.

State machine:
- All outputs are registered.
- IDLE: note=15. A start pulse moves to FETCH and clears index to 0.
- FETCH (1 cycle): reads ROM[index].
  - If the entry is an end marker: done=1 for the next cycle, index returns to 0, go to IDLE.
  - Otherwise: load cnt = dur*BEAT_CYCLES - GAP_CYCLES - 1, go to PLAY.
- PLAY: note=code. cnt decrements each cycle; at cnt=0, load cnt=GAP_CYCLES-1 and go to GAP.
- GAP: note=15. At cnt=0, increment index and go to FETCH.
- PAUSED: note=15, and cnt and index are frozen. A pause pulse returns to the saved state (PLAY or GAP) with the remaining count, and note resumes the next cycle.

Timing:
- Note output appears on the second edge after start is sampled.
- Each note occupies exactly dur*BEAT_CYCLES+1 cycles: PLAY, then GAP, then FETCH.

Priority and ignored inputs:
- stop beats pause, which beats start, when they arrive in the same cycle.
- stop in any non-IDLE state: next cycle IDLE, note=15, index=0, done not asserted.
- start outside IDLE is ignored. pause in IDLE or FETCH is ignored.

Arithmetic:
- dur*BEAT_CYCLES is computed at 32-bit width.
- Counters never wrap; they load only at state entry.

Optional Feature:
- Macro SONG_LOOP_EN.
- When defined: on the end marker, done still pulses for one cycle, but the block goes to FETCH with index=0 instead of IDLE. Playback repeats until stop.
- When undefined: the block returns to IDLE at end of song, as described above.

Test Plan (BEAT_CYCLES=10, GAP_CYCLES=2):
- Reset: hold RESET=0 with start=1 -> note=15, playing=0, index=0, done=0. After release with no start, the block stays IDLE.
- Single note: start pulse at edge 0 -> note=2 (E) for edges 2-9, then note=15 for 2 cycles and for the FETCH cycle; index=1 at edge 12; note=2 again from edge 13.
- Full song: start, run with no other input -> 15 notes in ROM order, 2-beat notes held 18 cycles, done high exactly once, then IDLE with playing=0. Total time start to done = 17*10 + 15 + 1 cycles.
- Pause/resume: pause 3 cycles into note index 3 (G), wait 50 cycles, pause again -> note=15 and index=3 frozen during the wait; G resumes for the remaining 5 PLAY cycles.
- Stop mid-GAP, and simultaneous stop+pause -> IDLE on the next cycle, note=15, index=0, no done pulse. A new start replays from index 0.
- With SONG_LOOP_EN: run 2 passes -> done pulses twice; after the end marker, index returns to 0 and note=2 replays without a start pulse.
